// File: rtl/updown_btn_cmd.sv
// Up/down pushbutton command stage: sync, debounce, press arbiter, pulse out.
// Define AUTO_REPEAT_EN to add hold-to-repeat pulses in the held states.
module updown_btn_cmd #(
  parameter int DEB_CYCLES    = 16,
  parameter int DEB_W         = 8,
  parameter int REPEAT_DELAY  = 64,
  parameter int REPEAT_PERIOD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic       up,
  output logic       down,
  output logic [1:0] deb_lvl
);

  typedef enum logic [1:0] {
    IDLE,
    HELD_UP,
    HELD_DN,
    LOCK
  } state_t;

  localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEB_CYCLES - 1);

  logic [1:0]       s1;
  logic [1:0]       s2;
  logic [1:0]       lvl_d;
  logic [DEB_W-1:0] cnt [2];
  logic [1:0]       rise;
  logic [1:0]       fall;
  logic             rpt;
  state_t           st;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= {btn_down, btn_up};
      s2 <= s1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      deb_lvl <= '0;
      lvl_d   <= '0;
      cnt[0]  <= '0;
      cnt[1]  <= '0;
    end else begin
      lvl_d <= deb_lvl;
      for (int i = 0; i < 2; i++) begin
        if (s2[i] == deb_lvl[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DEB_MAX) begin
          deb_lvl[i] <= ~deb_lvl[i];
          cnt[i]     <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  assign rise = deb_lvl & ~lvl_d;
  assign fall = ~deb_lvl & lvl_d;

`ifdef AUTO_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                        REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);

  logic [RW-1:0] rc;
  logic          held;

  assign held = (st == HELD_UP) || (st == HELD_DN);
  assign rpt  = held && (rc == '0);

  // countdown to the next repeat; reloads outside the held states
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rc <= '0;
    end else if (!held) begin
      rc <= RW'(REPEAT_DELAY - 1);
    end else if (rc == '0) begin
      rc <= RW'(REPEAT_PERIOD - 1);
    end else begin
      rc <= rc - 1'b1;
    end
  end
`else
  assign rpt = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st   <= IDLE;
      up   <= 1'b0;
      down <= 1'b0;
    end else begin
      up   <= 1'b0;
      down <= 1'b0;
      unique case (st)
        IDLE: begin
          if (rise == 2'b11) begin
            st <= LOCK;
          end else if (rise[0]) begin
            up <= 1'b1;
            st <= HELD_UP;
          end else if (rise[1]) begin
            down <= 1'b1;
            st   <= HELD_DN;
          end
        end
        HELD_UP: begin
          if (rise[1]) st <= LOCK;
          else if (fall[0]) st <= IDLE;
          else if (rpt) up <= 1'b1;
        end
        HELD_DN: begin
          if (rise[0]) st <= LOCK;
          else if (fall[1]) st <= IDLE;
          else if (rpt) down <= 1'b1;
        end
        LOCK: begin
          if (deb_lvl == 2'b00) st <= IDLE;
        end
      endcase
    end
  end

endmodule
